// File: rtl/mux_pkg.sv
// Shared constants and helpers for the 8-channel fan-in/fan-out datapath.
package mux_pkg;

   localparam int NUM_CH = 8;
   localparam int SEL_W  = 3;

   // Returns the LSB position of channel idx inside a flattened bus.
   function automatic int ch_lsb(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/rr_arbiter_8.sv
// Combinational 8-way rotating-priority arbiter: scans req upward from ptr with wrap.
module rr_arbiter_8
   import mux_pkg::*;
(
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   input  logic              en,
   output logic [NUM_CH-1:0] gnt,
   output logic [SEL_W-1:0]  gnt_idx,
   output logic              any
);

   logic [SEL_W-1:0] w_idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      w_idx   = '0;
      // 3-bit addition wraps 7->0, giving the circular scan order for free.
      for (int k = 0; k < NUM_CH; k++) begin
         w_idx = ptr + SEL_W'(k);
         if (en && !any && req[w_idx]) begin
            gnt[w_idx] = 1'b1;
            gnt_idx    = w_idx;
            any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_mux_8to1.sv
// Round-robin 8:1 fan-in: one registered output beat tagged with its source channel.
module rr_mux_8to1
   import mux_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_CH-1:0]         in_valid,
   input  logic [NUM_CH*WIDTH-1:0]   in_data,
   output logic [NUM_CH-1:0]         in_ready,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_sel,
   input  logic                      out_ready
);

   logic               r_out_valid;
   logic [WIDTH-1:0]   r_out_data;
   logic [SEL_W-1:0]   r_out_sel;
   logic [SEL_W-1:0]   r_ptr;

   logic               w_load;
   logic               w_en;
   logic [NUM_CH-1:0]  w_gnt;
   logic [SEL_W-1:0]   w_gnt_idx;
   logic               w_any;
   logic [WIDTH-1:0]   w_data;

   // Holding register accepts a beat when empty or draining this cycle.
   assign w_load = ~r_out_valid | out_ready;
   assign w_en   = w_load & ~reset;

   rr_arbiter_8 u_arb (
      .req     (in_valid),
      .ptr     (r_ptr),
      .en      (w_en),
      .gnt     (w_gnt),
      .gnt_idx (w_gnt_idx),
      .any     (w_any)
   );

   // Grant is one-hot, so an AND-OR select of the winning channel suffices.
   always_comb begin
      w_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_gnt[i]) w_data = in_data[ch_lsb(i, WIDTH) +: WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sel   <= '0;
         r_ptr       <= '0;
      end else if (w_any) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_data;
         r_out_sel   <= w_gnt_idx;
         r_ptr       <= w_gnt_idx + SEL_W'(1);
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign in_ready  = w_gnt;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_mux_8to1.sv
// Scoreboard bench for rr_mux_8to1: a reference arbiter predicts grants and output beats.
module tb_rr_mux_8to1;

   typedef struct packed {
      logic [2:0] sel;
      logic [7:0] data;
   } beat_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  in_valid;
   logic [63:0] in_data;
   logic [7:0]  in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [2:0]  out_sel;
   logic        out_ready;

   logic [7:0]  ch_data  [8];
   logic [7:0]  nxt_data [8];
   logic        rnd_mode = 1'b0;

   beat_t       q[$];
   logic        m_vld = 1'b0;
   logic [2:0]  m_ptr = 3'd0;
   logic        m_rst_seen = 1'b1;

   int          n_chk = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   always_comb begin
      in_data = '0;
      for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = ch_data[i];
   end

   rr_mux_8to1 #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs after negedge, check against the model, then advance it.
   task automatic cyc(input logic [7:0] vld, input logic rdy, input logic rst);
      logic [7:0] eg;
      logic [2:0] idx;
      logic [2:0] j;
      logic       found;
      @(negedge clk);
      for (int i = 0; i < 8; i++)
         ch_data[i] = rnd_mode ? 8'($urandom) : nxt_data[i];
      in_valid  = vld;
      out_ready = rdy;
      reset     = rst;
      #1;
      eg = '0; idx = '0; found = 1'b0;
      if (!rst && (!m_vld || rdy)) begin
         for (int k = 0; k < 8; k++) begin
            j = m_ptr + 3'(k);
            if (!found && vld[j]) begin
               found = 1'b1; idx = j; eg[j] = 1'b1;
            end
         end
      end
      chk("in_ready", 32'(in_ready), 32'(eg));
      chk("out_valid", 32'(out_valid), 32'(m_vld));
      if (m_rst_seen) begin
         chk("rst_out_sel", 32'(out_sel), 32'd0);
         chk("rst_out_data", 32'(out_data), 32'd0);
         m_rst_seen = 1'b0;
      end
      if (m_vld) begin
         if (q.size() == 0) chk("sb_empty", 32'(q.size()), 32'd1);
         else begin
            chk("out_sel", 32'(out_sel), 32'(q[0].sel));
            chk("out_data", 32'(out_data), 32'(q[0].data));
            if (rdy && !rst) void'(q.pop_front());
         end
      end
      if (rst) begin
         m_vld = 1'b0; m_ptr = 3'd0; q.delete(); m_rst_seen = 1'b1;
      end else if (found) begin
         q.push_back('{sel: idx, data: ch_data[idx]});
         m_ptr = idx + 3'd1;
         m_vld = 1'b1;
      end else if (rdy) begin
         m_vld = 1'b0;
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         nxt_data[i] = 8'h10 + 8'(i);
         ch_data[i]  = nxt_data[i];
      end
      reset = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
      @(posedge clk);

      // Reset held with all channels requesting.
      cyc(8'hFF, 1'b1, 1'b1);
      cyc(8'hFF, 1'b1, 1'b1);

      // Full contention: grants 0..7,0..7.
      for (int n = 0; n < 16; n++) cyc(8'hFF, 1'b1, 1'b0);
      cyc(8'h00, 1'b1, 1'b0);
      cyc(8'h00, 1'b1, 1'b0);

      // Backpressure: ch3 beat A5 held while out_ready low.
      nxt_data[3] = 8'hA5;
      cyc(8'h08, 1'b0, 1'b0);
      for (int n = 0; n < 5; n++) cyc(8'hFF, 1'b0, 1'b0);
      cyc(8'hFF, 1'b1, 1'b0);
      cyc(8'h00, 1'b1, 1'b0);

      // Idle drain after a single ch5 beat; pointer must stay at 6.
      cyc(8'h20, 1'b1, 1'b0);
      for (int n = 0; n < 4; n++) cyc(8'h00, 1'b1, 1'b0);

      // Sparse request with wrap from ptr=6: ch0 then ch1.
      cyc(8'h03, 1'b1, 1'b0);
      cyc(8'h03, 1'b1, 1'b0);
      cyc(8'h00, 1'b1, 1'b0);

      // Reset during a stall discards the held beat.
      cyc(8'h10, 1'b0, 1'b0);
      cyc(8'hFF, 1'b0, 1'b0);
      cyc(8'hFF, 1'b0, 1'b1);
      cyc(8'hFF, 1'b1, 1'b0);
      cyc(8'hFF, 1'b1, 1'b0);
      cyc(8'h00, 1'b1, 1'b0);

      // Random traffic with random data and backpressure.
      rnd_mode = 1'b1;
      for (int n = 0; n < 200; n++)
         cyc(8'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0);
      rnd_mode = 1'b0;
      for (int n = 0; n < 3; n++) cyc(8'h00, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
